lif_neuron_core: RTL
====================

Name: lif_neuron_core

Overview:
- Leaky integrate-and-fire neuron stage directly downstream of the input current calculator.
- Consumes the signed 8-bit weighted input current, once per enabled cycle.
- Maintains a saturating signed membrane potential with shift-based leak, fires a one-cycle spike at threshold, then enforces a refractory window.
- Its spike output feeds the next layer's spike vector; it also keeps a saturating spike counter for classification readout.

Parameters:
THRESHOLD, 64, signed 8-bit firing threshold; fire when updated potential >= THRESHOLD
V_RESET, 0, signed 8-bit potential loaded after a spike and held during refractory
LEAK_SHIFT, 3, arithmetic right-shift amount for leak term (0..7)
REFRACTORY_PERIOD, 2, enabled cycles after a spike during which input is ignored (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  timestep strobe; state advances only on edges where enable=1
input_current  input  8  signed two's-complement current from upstream stage
spike_out  output  1  registered one-cycle spike pulse
membrane_potential  output  8  signed current potential (registered)
refractory_active  output  1  high while in REFRACTORY state
spike_count  output  16  unsigned count of spikes, saturates at 16'hFFFF

Behaviour:
- Reset (async, immediate): membrane_potential=0, spike_out=0, refractory_active=0, spike_count=0, state=INTEGRATE, refractory counter=0.
- All outputs are registered; the result for an enabled edge is visible right after that edge (latency 1 clock).
- enable=0:
  - All state holds.
  - spike_out=0 on that edge; a spike pulse never lasts more than one clock.
- State INTEGRATE, enable=1:
  - leak = v >>> LEAK_SHIFT (arithmetic, floor toward -inf).
  - sum = v - leak + input_current, computed in 10-bit signed, sign-extended.
  - v_next = sum saturated to [-128, 127].
  - If v_next >= THRESHOLD (signed compare):
    - spike_out=1, v=V_RESET, spike_count+=1 (saturating).
    - If REFRACTORY_PERIOD>0: go to REFRACTORY with counter=REFRACTORY_PERIOD; else stay in INTEGRATE.
  - Otherwise: v=v_next, spike_out=0.
- State REFRACTORY, enable=1:
  - input_current is ignored; v is held at V_RESET; spike_out=0.
  - Counter decrements; when it reaches 0 on this edge, go to INTEGRATE.
  - The first integration uses the input present on the next enabled edge.
- refractory_active equals (state==REFRACTORY).
- Saturation is checked before threshold compare; a positive-saturated 127 fires whenever THRESHOLD <= 127.
- spike_count at 16'hFFFF stays 16'hFFFF on further spikes; spike_out still pulses.
- Reset asserted mid-refractory or mid-integration aborts immediately to reset values; no pending spike survives.
- Only the two states INTEGRATE and REFRACTORY exist; any other encoding recovers to INTEGRATE.

Test Plan:
1. Reset then idle:
   - Assert reset with enable toggling.
   - Required: all outputs 0, state INTEGRATE.
   - Required: outputs stay 0 for 5 cycles after release with enable=0.
2. Constant drive, defaults, input_current=20 every enabled cycle:
   - Required: v = 20, 38, 54, then spike_out=1 on the 4th edge (sum 68 >= 64), v=0, spike_count=1.
   - Required: refractory_active=1 for the next 2 enabled edges with v=0 despite input=20.
   - Required: 5th integration restarts at v=20.
3. Leak only:
   - input_current=40 once, then 0.
   - Required: v = 40, 35, 31, 28 (leaks 5, 4, 3).
4. Negative saturation:
   - input_current=-100 twice.
   - Required: v=-100, then -128 (sum -187 clamps), no spike.
5. Enable gating and mid-refractory reset:
   - Drop enable for 3 cycles in scenario 2 between v=38 and v=54.
   - Required: v holds 38, no spike_out.
   - Then assert reset during refractory; required: refractory_active=0, v=0, spike_count=0 immediately, without waiting for a clock.
6. Counter saturation and no refractory:
   - REFRACTORY_PERIOD=0, THRESHOLD=1, input_current=1 on every enabled edge.
   - Required: spike_out=1 on every enabled edge.
   - Required: with spike_count preset near max by a long run, it stops at 16'hFFFF.

Source files
------------

// File: rtl/lif_neuron_core.sv
// lif_neuron_core: leaky integrate-and-fire neuron with saturating potential, refractory window and spike counter
module lif_neuron_core #(
  parameter logic signed [7:0] THRESHOLD         = 8'sd64,
  parameter logic signed [7:0] V_RESET           = 8'sd0,
  parameter int unsigned       LEAK_SHIFT        = 3,
  parameter int unsigned       REFRACTORY_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [7:0] input_current,
  output logic              spike_out,
  output logic signed [7:0] membrane_potential,
  output logic              refractory_active,
  output logic [15:0]       spike_count
);
  typedef enum logic [1:0] {S_INT = 2'd0, S_REF = 2'd1} state_t;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic signed [7:0] r_v;
  logic              r_spike;
  logic [15:0]       r_count;
  logic signed [7:0] w_leak;
  logic signed [9:0] w_sum;
  logic signed [7:0] w_vnext;
  logic              w_fire;
  assign w_leak  = r_v >>> LEAK_SHIFT;
  assign w_sum   = {{2{r_v[7]}}, r_v} - {{2{w_leak[7]}}, w_leak} + {{2{input_current[7]}}, input_current};
  // clamp before the threshold compare so a saturated 127 can still fire
  assign w_vnext = (w_sum > 10'sd127) ? 8'h7F : (w_sum < -10'sd128) ? 8'h80 : w_sum[7:0];
  assign w_fire  = w_vnext >= THRESHOLD;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INT;
      r_cnt   <= '0;
      r_v     <= '0;
      r_spike <= 1'b0;
      r_count <= '0;
    end else if (!enable) begin
      r_spike <= 1'b0;
    end else begin
      case (r_state)
        S_INT: begin
          r_spike <= w_fire;
          r_v     <= w_fire ? V_RESET : w_vnext;
          if (w_fire) begin
            r_count <= r_count + {15'd0, r_count != 16'hFFFF};
            if (REFRACTORY_PERIOD != 0) begin
              r_state <= S_REF;
              r_cnt   <= 4'(REFRACTORY_PERIOD);
            end
          end
        end
        S_REF: begin
          r_spike <= 1'b0;
          r_v     <= V_RESET;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_INT;
        end
        default: begin
          r_state <= S_INT;
          r_spike <= 1'b0;
        end
      endcase
    end
  end
  assign spike_out          = r_spike;
  assign membrane_potential = r_v;
  assign refractory_active  = r_state == S_REF;
  assign spike_count        = r_count;
endmodule
